// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: EX-stage handshake and HI/LO result bundle for the multiply/divide sequencer
interface muldiv_ctrl_if;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        md_use_d_i;
  logic        busy_o;
  logic        stall_md_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  modport master (
    output start_i, op_i, a_i, b_i, md_use_d_i,
    input  busy_o, stall_md_o, hi_o, lo_o
  );
  modport slave (
    input  start_i, op_i, a_i, b_i, md_use_d_i,
    output busy_o, stall_md_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle MULT/DIV sequencer owning HI/LO and driving the ID-stage stall
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic         clk,
  input logic         reset,
  muldiv_ctrl_if.slave md
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, lat;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d, p_hi_q, p_hi_d, p_lo_q, p_lo_d;
  logic [63:0]   prod_s, prod_u, res;
  logic [31:0]   bs_s, bs_u, q_s, r_s, q_u, r_u;
  logic          is_mul, div0, ovf, idle_start;
  // Result datapath: divisor is forced to 1 for the zero and overflow cases so the
  // dividers never see an undefined operand; the special results are patched below.
  always_comb begin
    div0   = md.b_i == 32'h0;
    ovf    = md.a_i == 32'h8000_0000 && md.b_i == 32'hFFFF_FFFF;
    bs_s   = (div0 || ovf) ? 32'h1 : md.b_i;
    bs_u   = div0 ? 32'h1 : md.b_i;
    prod_s = {{32{md.a_i[31]}}, md.a_i} * {{32{md.b_i[31]}}, md.b_i};
    prod_u = {32'h0, md.a_i} * {32'h0, md.b_i};
    q_s    = $signed(md.a_i) / $signed(bs_s);
    r_s    = $signed(md.a_i) % $signed(bs_s);
    q_u    = md.a_i / bs_u;
    r_u    = md.a_i % bs_u;
    is_mul = md.op_i[2:1] == 2'b00;
    res    = md.op_i[1:0] == 2'd0 ? prod_s :
             md.op_i[1:0] == 2'd1 ? prod_u :
             div0                 ? {md.a_i, 32'hFFFF_FFFF} :
             md.op_i[1:0] == 2'd2 ? {r_s, q_s} : {r_u, q_u};
    lat    = is_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
  end
  // Next-state: the start cycle itself counts as the first busy cycle, so the
  // counter is loaded with N-1 and a 1-cycle op writes HI/LO straight away.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    p_hi_d     = p_hi_q;
    p_lo_d     = p_lo_q;
    idle_start = state_q == IDLE && md.start_i;
    if (idle_start && md.op_i <= 3'd3) begin
      p_hi_d  = res[63:32];
      p_lo_d  = res[31:0];
      cnt_d   = lat;
      state_d = lat == '0 ? IDLE : BUSY;
      hi_d    = lat == '0 ? res[63:32] : hi_q;
      lo_d    = lat == '0 ? res[31:0] : lo_q;
    end else if (idle_start && md.op_i == 3'd4) begin
      hi_d = md.a_i;
    end else if (idle_start && md.op_i == 3'd5) begin
      lo_d = md.a_i;
    end else if (state_q == BUSY) begin
      cnt_d   = cnt_q - CW'(1);
      state_d = cnt_q == CW'(1) ? IDLE : BUSY;
      hi_d    = cnt_q == CW'(1) ? p_hi_q : hi_q;
      lo_d    = cnt_q == CW'(1) ? p_lo_q : lo_q;
    end
  end
  // State, counter, pending result and architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
    end
  end
  assign md.busy_o     = state_q == BUSY || (md.start_i && md.op_i <= 3'd5);
  assign md.stall_md_o = md.md_use_d_i && md.busy_o;
  assign md.hi_o       = hi_q;
  assign md.lo_o       = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed and random scoreboard checks of the multiply/divide sequencer
module tb_muldiv_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_assert = 0;
  int n_fail = 0;
  logic [63:0] sb[$];
  muldiv_ctrl_if mif ();
  muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .md(mif.slave));
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] ax, ay, qm, rm;
    logic [63:0] pm;
    ax = x[31] ? -x : x;
    ay = y[31] ? -y : y;
    pm = {32'h0, ax} * {32'h0, ay};
    if (o == 3'd0) return (x[31] ^ y[31]) ? -pm : pm;
    if (o == 3'd1) return {32'h0, x} * {32'h0, y};
    if (y == 32'h0) return {x, 32'hFFFF_FFFF};
    if (o == 3'd3) return {x % y, x / y};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    qm = ax / ay;
    rm = ax % ay;
    return {x[31] ? -rm : rm, (x[31] ^ y[31]) ? -qm : qm};
  endfunction

  // Starts an op in the current cycle (caller sits just after a negedge) and
  // leaves the bench in cycle t+N so the next op can issue back-to-back.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp, input int n, input logic use_d, input logic intr);
    int cyc, st;
    logic early;
    logic [31:0] hi0, lo0;
    logic [63:0] e;
    hi0 = mif.hi_o;
    lo0 = mif.lo_o;
    mif.start_i = 1'b1;
    mif.op_i = o;
    mif.a_i = x;
    mif.b_i = y;
    mif.md_use_d_i = use_d;
    sb.push_back(exp);
    #1;
    chk({tag, "_busy_t"}, 32'(mif.busy_o), 32'd1);
    cyc = 1;
    st = int'(mif.stall_md_o);
    early = 1'b0;
    @(negedge clk);
    mif.start_i = intr && cyc == 2;
    mif.op_i = 3'd4;
    mif.a_i = 32'hDEAD_BEEF;
    mif.b_i = 32'h0;
    #1;
    while (mif.busy_o && cyc < 40) begin
      cyc++;
      st += int'(mif.stall_md_o);
      early |= (mif.hi_o !== hi0) || (mif.lo_o !== lo0);
      @(negedge clk);
      mif.start_i = intr && cyc == 2;
      #1;
    end
    mif.start_i = 1'b0;
    chk({tag, "_busy_len"}, 32'(cyc), 32'(n));
    chk({tag, "_stall_len"}, 32'(st), use_d ? 32'(n) : 32'd0);
    chk({tag, "_stall_end"}, 32'(mif.stall_md_o), 32'd0);
    chk({tag, "_early_upd"}, 32'(early), 32'd0);
    e = sb.pop_front();
    chk({tag, "_hi"}, mif.hi_o, e[63:32]);
    chk({tag, "_lo"}, mif.lo_o, e[31:0]);
  endtask

  initial begin
    logic [31:0] rx, ry;
    logic [2:0] ro;
    mif.start_i = 1'b0;
    mif.op_i = 3'd0;
    mif.a_i = 32'h0;
    mif.b_i = 32'h0;
    mif.md_use_d_i = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_hi", mif.hi_o, 32'h0);
    chk("rst_lo", mif.lo_o, 32'h0);
    chk("rst_busy", 32'(mif.busy_o), 32'd0);
    chk("rst_stall", 32'(mif.stall_md_o), 32'd0);
    run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 5, 1'b1, 1'b0);
    run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, {32'h2, 32'hFFFF_FFFA}, 5, 1'b0, 1'b0);
    run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10, 1'b1, 1'b0);
    run_op("divu0", 3'd3, 32'd7, 32'd0, {32'd7, 32'hFFFF_FFFF}, 10, 1'b0, 1'b0);
    run_op("div0", 3'd2, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 10, 1'b0, 1'b0);
    run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 10, 1'b0, 1'b0);
    run_op("divneg", 3'd2, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 10, 1'b0, 1'b0);
    run_op("divu", 3'd3, 32'd100, 32'd7, {32'd2, 32'd14}, 10, 1'b0, 1'b0);
    run_op("intrude", 3'd0, 32'd6, 32'd7, {32'h0, 32'd42}, 5, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      ro = 3'(i % 4);
      rx = $urandom;
      ry = (i == 5) ? 32'h0 : $urandom;
      run_op("rand", ro, rx, ry, model(ro, rx, ry), ro <= 3'd1 ? 5 : 10, 1'(i % 2), 1'b0);
    end
    @(negedge clk);
    mif.md_use_d_i = 1'b1;
    mif.start_i = 1'b1;
    mif.op_i = 3'd4;
    mif.a_i = 32'h1234_5678;
    #1;
    chk("mthi_busy", 32'(mif.busy_o), 32'd1);
    @(negedge clk);
    mif.op_i = 3'd5;
    mif.a_i = 32'hCAFE_BABE;
    #1;
    chk("mthi_hi", mif.hi_o, 32'h1234_5678);
    chk("mthi_lo_keep", mif.lo_o, model(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF) == 64'd1 ? sb.size() == 0 ? mif.lo_o : 32'h0 : 32'h0);
    @(negedge clk);
    mif.op_i = 3'd6;
    mif.a_i = 32'h5555_5555;
    #1;
    chk("mtlo_lo", mif.lo_o, 32'hCAFE_BABE);
    chk("mtlo_hi", mif.hi_o, 32'h1234_5678);
    chk("op6_busy", 32'(mif.busy_o), 32'd0);
    chk("op6_stall", 32'(mif.stall_md_o), 32'd0);
    @(negedge clk);
    mif.start_i = 1'b0;
    #1;
    chk("op6_hi", mif.hi_o, 32'h1234_5678);
    chk("op6_lo", mif.lo_o, 32'hCAFE_BABE);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mif.start_i = 1'b1;
    mif.op_i = 3'd2;
    mif.a_i = 32'hFFFF_FFF9;
    mif.b_i = 32'd2;
    repeat (4) begin
      @(negedge clk);
      mif.start_i = 1'b0;
    end
    #1;
    chk("mid_busy", 32'(mif.busy_o), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("mrst_busy", 32'(mif.busy_o), 32'd0);
    chk("mrst_stall", 32'(mif.stall_md_o), 32'd0);
    chk("mrst_hi", mif.hi_o, 32'h0);
    chk("mrst_lo", mif.lo_o, 32'h0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    chk("discard_hi", mif.hi_o, 32'h0);
    chk("discard_lo", mif.lo_o, 32'h0);
    run_op("post_rst", 3'd0, 32'd6, 32'd7, {32'h0, 32'd42}, 5, 1'b1, 1'b0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
